// File: rtl/store_write_buffer.sv
// Store write buffer: decodes size/offset into big-endian byte lanes, filters by partition and alignment, queues in a FIFO.
// Latency: an accepted legal store appears on mem_valid the cycle after acceptance (no fall-through).
// Backpressure: req_ready = !full; the head is held on mem_* until mem_ready; full blocks merges too.
module store_write_buffer #(
  parameter int         DATA_W     = 32,
  parameter int         ADDR_W     = 32,
  parameter int         DEPTH      = 4,
  parameter logic [3:0] PART_MASK  = 4'b1001,
  parameter logic [3:0] PART_MATCH = 4'b0001,
  parameter bit         COALESCE   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_size,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_data,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic [DATA_W/8-1:0]         mem_we,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        misalign_err,
  output logic                        range_drop
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  we;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  last_idx;

  logic [3:0]        top_nib;
  logic              in_range;
  logic [OFF_W-1:0]  off;
  logic [3:0]        nbytes;
  logic              size_bad;
  logic [OFF_W-1:0]  align_mask;
  logic              align_bad;
  logic              legal;
  logic [ADDR_W-1:0] word_addr;
  logic [LANES-1:0]  new_we;
  logic [DATA_W-1:0] new_bmask;
  logic [DATA_W-1:0] left_just;
  logic [DATA_W-1:0] new_data;

  logic              accept;
  logic              pop;
  logic              merge;
  logic              push;

  // Request classification: partition, size legality, natural alignment.
  assign top_nib    = req_addr[ADDR_W-1 -: 4];
  assign in_range   = (top_nib & PART_MASK) == PART_MATCH;
  assign off        = req_addr[OFF_W-1:0];
  assign nbytes     = 4'd1 << req_size;
  assign size_bad   = int'(nbytes) > LANES;
  assign align_mask = OFF_W'(nbytes - 4'd1);
  assign align_bad  = |(off & align_mask);
  assign legal      = in_range & ~size_bad & ~align_bad;
  assign word_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Lane enables: lane l holds byte offset LANES-1-l, enabled when inside [off, off+nbytes).
  always_comb begin
    new_we    = '0;
    new_bmask = '0;
    if (!size_bad) begin
      for (int l = 0; l < LANES; l++) begin
        if (((LANES - 1 - l) >= int'(off)) && ((LANES - 1 - l) < (int'(off) + int'(nbytes)))) begin
          new_we[l]            = 1'b1;
          new_bmask[l*8 +: 8]  = 8'hFF;
        end
      end
    end
  end

  // Steering: left-justify the store so its MSB byte sits at offset 0, then shift down to the offset.
  assign left_just = req_data << (8 * (LANES - int'(nbytes)));
  assign new_data  = (left_just >> (8 * int'(off))) & new_bmask;

  assign mem_valid = count_q != '0;
  assign empty     = count_q == '0;
  assign full      = count_q == FULL_CNT;
  assign req_ready = ~full;
  assign count     = count_q;

  // Outputs are zeroed while empty so stale entries never leak onto the port.
  assign mem_addr  = mem_valid ? fifo_q[head_q].addr : '0;
  assign mem_data  = mem_valid ? fifo_q[head_q].data : '0;
  assign mem_we    = mem_valid ? fifo_q[head_q].we   : '0;

  assign last_idx  = tail_q - PTR_W'(1);
  assign accept    = req_valid & req_ready;
  assign pop       = mem_valid & mem_ready;

  // A lone entry leaving this cycle cannot absorb a merge; the store becomes a fresh push instead.
  assign merge = COALESCE && accept && legal && (count_q != '0) &&
                 (fifo_q[last_idx].addr == word_addr) &&
                 !((count_q == CNT_W'(1)) && pop);
  assign push  = accept & legal & ~merge;

  // Entry storage: validity is tracked by the pointers and count, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[tail_q].addr <= word_addr;
      fifo_q[tail_q].data <= new_data;
      fifo_q[tail_q].we   <= new_we;
    end else if (merge) begin
      fifo_q[last_idx].we   <= fifo_q[last_idx].we | new_we;
      fifo_q[last_idx].data <= (fifo_q[last_idx].data & ~new_bmask) | new_data;
    end
  end

  // Pointer, occupancy and drop-pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      misalign_err <= 1'b0;
      range_drop   <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      count_q      <= count_q + CNT_W'(push) - CNT_W'(pop);
      misalign_err <= accept & in_range & (size_bad | align_bad);
      range_drop   <= accept & ~in_range;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_we;
  logic [2:0]  count;
  logic        full, empty, misalign_err, range_drop;

  logic        w_req_valid = 1'b0;
  logic        w_req_ready;
  logic [1:0]  w_req_size = 2'b00;
  logic [31:0] w_req_addr = '0;
  logic [63:0] w_req_data = '0;
  logic        w_mem_valid;
  logic        w_mem_ready = 1'b0;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_data;
  logic [7:0]  w_mem_we;
  logic [2:0]  w_count;
  logic        w_full, w_empty, w_misalign_err, w_range_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we),
    .count(count), .full(full), .empty(empty),
    .misalign_err(misalign_err), .range_drop(range_drop)
  );

  store_write_buffer #(.DATA_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_size(w_req_size),
    .req_addr(w_req_addr), .req_data(w_req_data),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
    .mem_data(w_mem_data), .mem_we(w_mem_we),
    .count(w_count), .full(w_full), .empty(w_empty),
    .misalign_err(w_misalign_err), .range_drop(w_range_drop)
  );

  // One request cycle on the 32-bit instance; returns 1 ns after the accepting edge.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_size = sz; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic w_store(input logic [1:0] sz, input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    w_req_valid = 1'b1; w_req_size = sz; w_req_addr = a; w_req_data = d;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
  endtask

  task automatic drain_one;
    @(negedge clk); mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #20;
    tests++; if ({mem_valid, mem_we, mem_addr, mem_data} !== 69'd0) begin fails++; $display("FAIL reset_mem: got v=%b we=%h a=%h d=%h want all 0", mem_valid, mem_we, mem_addr, mem_data); end
    tests++; if ({empty, full, misalign_err, range_drop, req_ready, count} !== 8'b1_0_0_0_1_000) begin fails++; $display("FAIL reset_flags: got e=%b f=%b me=%b rd=%b rr=%b c=%0d want e=1 f=0 me=0 rd=0 rr=1 c=0", empty, full, misalign_err, range_drop, req_ready, count); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_byte;
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h1000_0002; req_data = 32'h0000_00AB;
    #1;
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL byte_no_fallthrough: mem_valid got %b want 0", mem_valid); end
    @(posedge clk); #1; req_valid = 1'b0;
    tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h1000_0000) begin fails++; $display("FAIL byte_head: got v=%b a=%h want v=1 a=10000000", mem_valid, mem_addr); end
    tests++; if (mem_we !== 4'b0010 || mem_data !== 32'h0000_AB00) begin fails++; $display("FAIL byte_lanes: got we=%b d=%h want we=0010 d=0000ab00", mem_we, mem_data); end
    drain_one();
    tests++; if (empty !== 1'b1 || mem_valid !== 1'b0 || mem_we !== 4'b0000) begin fails++; $display("FAIL byte_drained: got e=%b v=%b we=%b want e=1 v=0 we=0000", empty, mem_valid, mem_we); end
  endtask

  task automatic test_coalesce;
    do_store(2'b01, 32'h1000_0002, 32'h0000_1234);
    do_store(2'b01, 32'h1000_0000, 32'h0000_5678);
    tests++; if (count !== 3'd1 || mem_we !== 4'b1111 || mem_data !== 32'h5678_1234) begin fails++; $display("FAIL coalesce_merge: got c=%0d we=%b d=%h want c=1 we=1111 d=56781234", count, mem_we, mem_data); end
    do_store(2'b10, 32'h1000_0004, 32'hDEAD_BEEF);
    tests++; if (count !== 3'd2 || mem_addr !== 32'h1000_0000) begin fails++; $display("FAIL coalesce_newword: got c=%0d a=%h want c=2 a=10000000", count, mem_addr); end
    drain_one();
    tests++; if (mem_addr !== 32'h1000_0004 || mem_data !== 32'hDEAD_BEEF || mem_we !== 4'b1111) begin fails++; $display("FAIL coalesce_second: got a=%h d=%h we=%b want a=10000004 d=deadbeef we=1111", mem_addr, mem_data, mem_we); end
    drain_one();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL coalesce_empty: got %b want 1", empty); end
  endtask

  task automatic test_merge_vs_pop;
    do_store(2'b00, 32'h1000_0003, 32'h0000_0011);
    tests++; if (mem_we !== 4'b0001 || mem_data !== 32'h0000_0011) begin fails++; $display("FAIL mvp_first: got we=%b d=%h want we=0001 d=00000011", mem_we, mem_data); end
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h1000_0000; req_data = 32'h0000_0022; mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    tests++; if (count !== 3'd1 || mem_we !== 4'b1000 || mem_data !== 32'h2200_0000) begin fails++; $display("FAIL mvp_push: got c=%0d we=%b d=%h want c=1 we=1000 d=22000000", count, mem_we, mem_data); end
    drain_one();
  endtask

  task automatic test_drops;
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h2000_0000; req_data = 32'h1111_1111;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL drop_ready: got %b want 1", req_ready); end
    @(posedge clk); #1; req_valid = 1'b0;
    tests++; if (range_drop !== 1'b1 || misalign_err !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL drop_range: got rd=%b me=%b c=%0d want rd=1 me=0 c=0", range_drop, misalign_err, count); end
    @(posedge clk); #1;
    tests++; if (range_drop !== 1'b0) begin fails++; $display("FAIL drop_range_pulse: got %b want 0", range_drop); end
    do_store(2'b01, 32'h1000_0001, 32'h0000_BEEF);
    tests++; if (misalign_err !== 1'b1 || range_drop !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL drop_misalign_h: got me=%b rd=%b c=%0d want me=1 rd=0 c=0", misalign_err, range_drop, count); end
    @(posedge clk); #1;
    tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL drop_misalign_pulse: got %b want 0", misalign_err); end
    do_store(2'b10, 32'h1000_0002, 32'h0000_0001);
    tests++; if (misalign_err !== 1'b1 || count !== 3'd0) begin fails++; $display("FAIL drop_misalign_w: got me=%b c=%0d want me=1 c=0", misalign_err, count); end
    do_store(2'b11, 32'h1000_0000, 32'h0000_0001);
    tests++; if (misalign_err !== 1'b1 || count !== 3'd0) begin fails++; $display("FAIL drop_dword32: got me=%b c=%0d want me=1 c=0", misalign_err, count); end
    do_store(2'b01, 32'h2000_0001, 32'h0000_0001);
    tests++; if (range_drop !== 1'b1 || misalign_err !== 1'b0) begin fails++; $display("FAIL drop_priority: got rd=%b me=%b want rd=1 me=0", range_drop, misalign_err); end
    do_store(2'b10, 32'h3000_0010, 32'hCAFE_0001);
    tests++; if (count !== 3'd1 || range_drop !== 1'b0 || mem_addr !== 32'h3000_0010) begin fails++; $display("FAIL drop_mask_dontcare: got c=%0d rd=%b a=%h want c=1 rd=0 a=30000010", count, range_drop, mem_addr); end
    drain_one();
  endtask

  task automatic test_full;
    logic [31:0] ea;
    logic [31:0] ed;
    for (int i = 0; i < 4; i++) do_store(2'b10, 32'h1000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    tests++; if (full !== 1'b1 || count !== 3'd4 || req_ready !== 1'b0) begin fails++; $display("FAIL full_flags: got f=%b c=%0d rr=%b want f=1 c=4 rr=0", full, count, req_ready); end
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h1000_0010; req_data = 32'hA000_0004;
    @(posedge clk); #1;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_blocked: got c=%0d want 4", count); end
    @(negedge clk); mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ea = 32'h1000_0000 + 32'(4 * i);
      ed = 32'hA000_0000 + 32'(i);
      tests++; if (mem_valid !== 1'b1 || mem_addr !== ea || mem_data !== ed) begin fails++; $display("FAIL full_order%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h", i, mem_valid, mem_addr, mem_data, ea, ed); end
      if (i == 2) begin
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_fifth_in: got c=%0d want 3", count); end
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    tests++; if (empty !== 1'b1 || count !== 3'd0) begin fails++; $display("FAIL full_drained: got e=%b c=%0d want e=1 c=0", empty, count); end
  endtask

  task automatic test_dword;
    w_store(2'b11, 32'h1000_0008, 64'h0123_4567_89AB_CDEF);
    tests++; if (w_mem_valid !== 1'b1 || w_mem_we !== 8'hFF || w_mem_addr !== 32'h1000_0008 || w_mem_data !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL dword64: got v=%b we=%h a=%h d=%h want v=1 we=ff a=10000008 d=0123456789abcdef", w_mem_valid, w_mem_we, w_mem_addr, w_mem_data); end
    w_store(2'b10, 32'h1000_000C, 64'h0000_0000_CAFE_F00D);
    tests++; if (w_count !== 3'd1 || w_mem_data !== 64'h0123_4567_CAFE_F00D) begin fails++; $display("FAIL dword64_merge: got c=%0d d=%h want c=1 d=01234567cafef00d", w_count, w_mem_data); end
    w_store(2'b11, 32'h1000_0004, 64'h1);
    tests++; if (w_misalign_err !== 1'b1 || w_count !== 3'd1) begin fails++; $display("FAIL dword64_misalign: got me=%b c=%0d want me=1 c=1", w_misalign_err, w_count); end
  endtask

  task automatic test_reset_mid;
    do_store(2'b10, 32'h1000_0100, 32'h1);
    do_store(2'b10, 32'h1000_0104, 32'h2);
    do_store(2'b10, 32'h1000_0108, 32'h3);
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL rmid_queued: got c=%0d want 3", count); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++; if (mem_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || mem_we !== 4'b0000) begin fails++; $display("FAIL rmid_async: got v=%b c=%0d e=%b we=%b want v=0 c=0 e=1 we=0000", mem_valid, count, empty, mem_we); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (mem_valid !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL rmid_after: got v=%b e=%b want v=0 e=1", mem_valid, empty); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_coalesce();
    test_merge_vs_pop();
    test_drops();
    test_full();
    test_dword();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
